// File: rtl/pacman_map_writer.sv
// pacman_map_writer: erases pacman's old map tile, draws him at the new tile, then pulses done.
// Build macro PACMAN_PACE_EN enforces at least PACE_TICKS cycles between successive moves.
module pacman_map_writer #(
    parameter int         COLS        = 40,
    parameter int         ROWS        = 30,
    parameter int         ADDR_W      = 11,
    parameter logic [3:0] TILE_EMPTY  = 4'd0,
    parameter logic [3:0] TILE_PACMAN = 4'd3,
    parameter int         PACE_TICKS  = 5_000_000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [5:0]        curr_pacman_x,
    input  logic [4:0]        curr_pacman_y,
    input  logic [5:0]        next_pacman_x,
    input  logic [4:0]        next_pacman_y,
    input  logic              ram_busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_data,
    output logic              done,
    output logic              err_oob,
    output logic [15:0]       move_count
);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

    state_t     state;
    logic [5:0] lat_curr_x;
    logic [4:0] lat_curr_y;
    logic [5:0] lat_next_x;
    logic [4:0] lat_next_y;
    logic       pace_ready;
    logic       move_req;
    logic       start;
    logic       curr_ok;
    logic       next_ok;

    function automatic logic [ADDR_W-1:0] tile_addr(input logic [5:0] x, input logic [4:0] y);
        return ADDR_W'(y) * ADDR_W'(COLS) + ADDR_W'(x);
    endfunction

    function automatic logic in_range(input logic [5:0] x, input logic [4:0] y);
        return (int'(x) < COLS) && (int'(y) < ROWS);
    endfunction

    assign move_req = {next_pacman_x, next_pacman_y} != {curr_pacman_x, curr_pacman_y};

    // While done is high the controller has not yet committed next into curr,
    // so a still-visible mismatch must not restart the sequence.
    assign start = (state == IDLE) && !done && pace_ready && move_req;

    assign curr_ok = in_range(lat_curr_x, lat_curr_y);
    assign next_ok = in_range(lat_next_x, lat_next_y);

    always_ff @(posedge CLOCK_50) begin
        if (start) begin
            lat_curr_x <= curr_pacman_x;
            lat_curr_y <= curr_pacman_y;
            lat_next_x <= next_pacman_x;
            lat_next_y <= next_pacman_y;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            done       <= 1'b0;
            err_oob    <= 1'b0;
            move_count <= '0;
        end else begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) state <= ERASE;
                end
                ERASE: begin
                    if (!ram_busy) begin
                        if (curr_ok) begin
                            wr_en   <= 1'b1;
                            wr_addr <= tile_addr(lat_curr_x, lat_curr_y);
                            wr_data <= TILE_EMPTY;
                        end else begin
                            err_oob <= 1'b1;
                        end
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    if (!ram_busy) begin
                        if (next_ok) begin
                            wr_en   <= 1'b1;
                            wr_addr <= tile_addr(lat_next_x, lat_next_y);
                            wr_data <= TILE_PACMAN;
                        end else begin
                            err_oob <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    if (move_count != 16'hFFFF) move_count <= move_count + 16'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PACMAN_PACE_EN
    logic [31:0] pace_cnt;

    // Reloads on the same edge that raises done, then counts down to zero.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pace_cnt <= '0;
        end else if (state == DONE) begin
            pace_cnt <= 32'(PACE_TICKS - 1);
        end else if (pace_cnt != 32'd0) begin
            pace_cnt <= pace_cnt - 32'd1;
        end
    end

    assign pace_ready = (pace_cnt == 32'd0);
`else
    assign pace_ready = (PACE_TICKS >= 0);
`endif

endmodule

// File: tb/tb_pacman_map_writer.sv
// Directed and randomized bench for pacman_map_writer against a move-level reference model.
`timescale 1ns/1ps
module tb_pacman_map_writer;
    localparam int ADDR_W = 11;

    logic              CLOCK_50 = 1'b0;
    logic              reset = 1'b1;
    logic [5:0]        curr_x = 6'd0;
    logic [4:0]        curr_y = 5'd0;
    logic [5:0]        next_x = 6'd0;
    logic [4:0]        next_y = 5'd0;
    logic              ram_busy = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_data;
    logic              done;
    logic              err_oob;
    logic [15:0]       move_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_count = 0;
    bit m_err = 1'b0;

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    pacman_map_writer #(
        .COLS(40), .ROWS(30), .ADDR_W(ADDR_W),
        .TILE_EMPTY(4'd0), .TILE_PACMAN(4'd3), .PACE_TICKS(8)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .curr_pacman_x(curr_x), .curr_pacman_y(curr_y),
        .next_pacman_x(next_x), .next_pacman_y(next_y),
        .ram_busy(ram_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(done), .err_oob(err_oob), .move_count(move_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic bit on_map(input int x, input int y);
        return (x < 40) && (y < 30);
    endfunction

    function automatic int addr_of(input int x, input int y);
        return y * 40 + x;
    endfunction

    // One move under random ram_busy: expected writes are the erase of the old
    // tile and the draw of the new one, each dropped when its tile is off-map.
    task automatic run_move(input int nx, input int ny, input int busy_pct);
        int a_q[$];
        int d_q[$];
        int cx;
        int cy;
        int ea;
        int ed;
        bit busy_edge;
        bit seen_done;
        cx = int'(curr_x);
        cy = int'(curr_y);
        seen_done = 1'b0;
        if (on_map(cx, cy)) begin a_q.push_back(addr_of(cx, cy)); d_q.push_back(0); end
        if (on_map(nx, ny)) begin a_q.push_back(addr_of(nx, ny)); d_q.push_back(3); end
        if (!(on_map(cx, cy) && on_map(nx, ny))) m_err = 1'b1;
        if (m_count < 65535) m_count++;
        next_x = 6'(nx);
        next_y = 5'(ny);
        for (int c = 0; c < 200 && !seen_done; c++) begin
            ram_busy = ($urandom_range(99) < busy_pct);
            busy_edge = ram_busy;
            step();
            if (wr_en) begin
                chk("rnd_write_while_busy", 32'(busy_edge), 0);
                chk("rnd_write_expected", 32'(a_q.size() > 0), 1);
                if (a_q.size() > 0) begin
                    ea = a_q.pop_front();
                    ed = d_q.pop_front();
                    chk("rnd_addr", 32'(wr_addr), ea);
                    chk("rnd_data", 32'(wr_data), ed);
                end
            end else begin
                chk("rnd_idle_addr", 32'(wr_addr), 0);
                chk("rnd_idle_data", 32'(wr_data), 0);
            end
            if (done) seen_done = 1'b1;
        end
        ram_busy = 1'b0;
        chk("rnd_done_seen", 32'(seen_done), 1);
        chk("rnd_writes_left", a_q.size(), 0);
        chk("rnd_move_count", 32'(move_count), m_count);
        chk("rnd_err_oob", 32'(err_oob), 32'(m_err));
        curr_x = next_x;
        curr_y = next_y;
        step();
        chk("rnd_no_refire", 32'(wr_en | done), 0);
    endtask

    initial begin
        int nx;
        int ny;
        // Test 1: reset state and no activity while curr == next
        curr_x = 6'd20; curr_y = 5'd20; next_x = 6'd20; next_y = 5'd20;
        reset = 1'b1;
        idle(2);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err_oob", 32'(err_oob), 0);
        chk("rst_move_count", 32'(move_count), 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t1_wr_en", 32'(wr_en), 0);
            chk("t1_done", 32'(done), 0);
        end
        chk("t1_move_count", 32'(move_count), 0);

        // Test 2: (20,20) -> (20,19), no stalls
        next_y = 5'd19;
        step();
        chk("t2_n_wr_en", 32'(wr_en), 0);
        step();
        chk("t2_erase_en", 32'(wr_en), 1);
        chk("t2_erase_addr", 32'(wr_addr), 820);
        chk("t2_erase_data", 32'(wr_data), 0);
        step();
        chk("t2_draw_en", 32'(wr_en), 1);
        chk("t2_draw_addr", 32'(wr_addr), 780);
        chk("t2_draw_data", 32'(wr_data), 3);
        step();
        chk("t2_done", 32'(done), 1);
        chk("t2_done_wr_en", 32'(wr_en), 0);
        chk("t2_move_count", 32'(move_count), 1);
        curr_y = 5'd19;
        step();
        chk("t2_done_pulse", 32'(done), 0);
        chk("t2_no_refire", 32'(wr_en), 0);
        idle(10);

        // Test 3: (20,19) -> (20,20) with ram_busy high for three edges
        next_y = 5'd20;
        step();
        ram_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_busy_hold", 32'(wr_en), 0);
        end
        ram_busy = 1'b0;
        step();
        chk("t3_erase_en", 32'(wr_en), 1);
        chk("t3_erase_addr", 32'(wr_addr), 780);
        chk("t3_erase_data", 32'(wr_data), 0);
        step();
        chk("t3_draw_en", 32'(wr_en), 1);
        chk("t3_draw_addr", 32'(wr_addr), 820);
        chk("t3_draw_data", 32'(wr_data), 3);
        step();
        chk("t3_done", 32'(done), 1);
        chk("t3_move_count", 32'(move_count), 2);
        curr_y = 5'd20;
        idle(10);

        // Test 4: (20,20) -> (40,20), draw suppressed
        next_x = 6'd40;
        step();
        step();
        chk("t4_erase_en", 32'(wr_en), 1);
        chk("t4_erase_addr", 32'(wr_addr), 820);
        step();
        chk("t4_draw_suppressed", 32'(wr_en), 0);
        chk("t4_draw_addr_zero", 32'(wr_addr), 0);
        chk("t4_err_oob", 32'(err_oob), 1);
        step();
        chk("t4_done", 32'(done), 1);
        chk("t4_move_count", 32'(move_count), 3);
        curr_x = 6'd40;
        idle(10);
        chk("t4_err_sticky", 32'(err_oob), 1);

        // Test 5: reset while the draw write is pending
        curr_x = 6'd20; curr_y = 5'd20; next_x = 6'd5; next_y = 5'd5;
        step();
        step();
        chk("t5_erase_en", 32'(wr_en), 1);
        reset = 1'b1;
        step();
        chk("t5_abort_wr_en", 32'(wr_en), 0);
        chk("t5_abort_done", 32'(done), 0);
        chk("t5_abort_count", 32'(move_count), 0);
        chk("t5_abort_err", 32'(err_oob), 0);
        curr_x = 6'd5; curr_y = 5'd5;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_quiet", 32'(wr_en | done), 0);
        end
        next_x = 6'd6;
        step();
        step();
        chk("t5_restart_erase", 32'(wr_addr), 205);
        step();
        chk("t5_restart_draw", 32'(wr_addr), 206);
        step();
        chk("t5_restart_done", 32'(done), 1);
        chk("t5_restart_count", 32'(move_count), 1);
        curr_x = 6'd6;
        step();
        m_count = 1;
        m_err = 1'b0;

        // Randomized moves against the move-level model
        for (int m = 0; m < 40; m++) begin
            do begin
                if ($urandom_range(9) == 0) begin
                    nx = int'($urandom_range(63));
                    ny = int'($urandom_range(31));
                end else begin
                    nx = int'($urandom_range(39));
                    ny = int'($urandom_range(29));
                end
            end while (nx == int'(curr_x) && ny == int'(curr_y));
            run_move(nx, ny, 35);
        end

`ifdef PACMAN_PACE_EN
        // Test 6: back-to-back requests are spaced by the pace counter
        begin
            int d_cyc;
            int w_cyc;
            bit got;
            reset = 1'b1;
            curr_x = 6'd1; curr_y = 5'd1; next_x = 6'd1; next_y = 5'd1;
            idle(2);
            reset = 1'b0;
            next_x = 6'd2;
            got = 1'b0;
            d_cyc = 0;
            for (int c = 0; c < 20 && !got; c++) begin
                step();
                if (done) begin got = 1'b1; d_cyc = cyc; end
            end
            chk("t6_first_done", 32'(got), 1);
            curr_x = 6'd2;
            next_x = 6'd3;
            got = 1'b0;
            w_cyc = 0;
            for (int c = 0; c < 40 && !got; c++) begin
                step();
                if (wr_en) begin got = 1'b1; w_cyc = cyc; end
            end
            chk("t6_second_write", 32'(got), 1);
            chk("t6_pace_gap_ok", 32'((w_cyc - d_cyc) >= 8), 1);
            chk("t6_erase_addr", 32'(wr_addr), 42);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
